// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding used by the serial_subtractor control FSM.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// One-bit half subtractor cell: d = x - y, bo = borrow out.
// Two of these plus an OR make the full-subtract step.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock.
// start/busy/done handshake; diff and bout hold until the next completion.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             d1;
    logic             bo1;
    logic             d_bit;
    logic             bo2;
    logic             nb;
    logic [WIDTH-1:0] res_nxt;

    half_subtractor u_hs1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (d1),
        .bo (bo1)
    );

    half_subtractor u_hs2 (
        .x  (d1),
        .y  (borrow),
        .d  (d_bit),
        .bo (bo2)
    );

    assign nb      = bo1 | bo2;
    assign res_nxt = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Result fills from the MSB end so it is aligned after WIDTH shifts.
                    res    <= res_nxt;
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= nb;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        diff  <= res_nxt;
                        bout  <= nb;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Expected results queue up at start and are compared on done.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x - y;
        exp_q.push_back({d, (x < y)});
    endtask

    // Presents operands with start for one edge; returns at the negedge after accept.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        push_exp(x, y);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_n, output int both);
        cyc = 0;
        busy_n = 0;
        both = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
        if (busy && done) both++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        a = 8'd7;
        b = 8'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (diff !== 8'd0) begin
            errors++;
            $display("FAIL reset_diff: got %0d want 0", diff);
        end
        checks++;
        if (bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_bout: got %b want 0", bout);
        end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [W-1:0] ta[5];
        logic [W-1:0] tb[5];
        logic [W:0]   e;
        int cyc;
        int bn;
        int both;
        ta = '{8'd200, 8'd5, 8'd0, 8'd0, 8'd255};
        tb = '{8'd55, 8'd10, 8'd1, 8'd0, 8'd255};
        for (int i = 0; i < 5; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(cyc, bn, both);
            checks++;
            if (cyc != W) begin
                errors++;
                $display("FAIL arith%0d_latency: got %0d want %0d", i, cyc, W);
            end
            checks++;
            if (bn != W) begin
                errors++;
                $display("FAIL arith%0d_busy_cycles: got %0d want %0d", i, bn, W);
            end
            checks++;
            if (both != 0) begin
                errors++;
                $display("FAIL arith%0d_busy_and_done: busy=%b done=%b", i, busy, done);
            end
            e = exp_q.pop_front();
            checks++;
            if (diff !== e[W:1]) begin
                errors++;
                $display("FAIL arith%0d_diff: got %0d want %0d", i, diff, e[W:1]);
            end
            checks++;
            if (bout !== e[0]) begin
                errors++;
                $display("FAIL arith%0d_bout: got %b want %b", i, bout, e[0]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL arith%0d_done_pulse: got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [W:0] e;
        logic [W-1:0] held;
        int cyc;
        int bn;
        int both;
        int extra;
        held = diff;
        start_op(8'd100, 8'd1);
        repeat (2) @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (diff !== held) begin
            errors++;
            $display("FAIL ignore_diff_hold: got %0d want %0d", diff, held);
        end
        wait_done(cyc, bn, both);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL ignore_timeout: done got 0 want 1");
        end
        e = exp_q.pop_front();
        checks++;
        if ({diff, bout} !== e) begin
            errors++;
            $display("FAIL ignore_result: got %0d/%b want %0d/%b",
                     diff, bout, e[W:1], e[0]);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_extra_done: got %0d want 0", extra);
        end
    endtask

    task automatic test_rst_abort;
        int pulses;
        logic [W:0] e;
        start_op(8'd50, 8'd20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({busy, done, diff, bout} !== {2'b00, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_state: got busy=%b done=%b diff=%0d bout=%b want 0/0/0/0 (dropped %0d)",
                     busy, done, diff, bout, e[W:1]);
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] e;
        int t0;
        int t1;
        int n;
        int cyc;
        int drift;
        @(negedge clk);
        a = 8'd30;
        b = 8'd10;
        start = 1'b1;
        push_exp(8'd30, 8'd10);
        push_exp(8'd10, 8'd30);
        n = 0;
        t0 = -1;
        t1 = -1;
        drift = 0;
        cyc = 0;
        while (n < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = exp_q.pop_front();
                checks++;
                if ({diff, bout} !== e) begin
                    errors++;
                    $display("FAIL b2b%0d_result: got %0d/%b want %0d/%b",
                             n, diff, bout, e[W:1], e[0]);
                end
                if (n == 0) begin
                    t0 = cyc;
                    a = 8'd10;
                    b = 8'd30;
                end else begin
                    t1 = cyc;
                    start = 1'b0;
                end
                n++;
            end else if (n == 1 && diff !== 8'd20) begin
                drift++;
            end
        end
        start = 1'b0;
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses want 2", n);
        end
        checks++;
        if (t1 - t0 != W + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d", t1 - t0, W + 1);
        end
        checks++;
        if (drift != 0) begin
            errors++;
            $display("FAIL b2b_diff_stable: got %0d changed cycles want 0", drift);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_arith();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
